// File: rtl/spi_bitmap_writer.sv
// SPI mode-0 slave front end: oversamples the SPI pins in the pixel clock domain,
// assembles MSB-first bytes and turns them into bitmap RAM writes or command strobes.
module spi_bitmap_writer #(
  parameter int WIDTH      = 128,
  parameter int HEIGHT     = 96,
  parameter int DEPTH      = WIDTH * HEIGHT / 8,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  CS_i,
  input  logic                  SCK_i,
  input  logic                  MOSI_i,
  input  logic                  DC_i,
  output logic                  WriteEnable_o,
  output logic [ADDR_WIDTH-1:0] WriteAddress_o,
  output logic [7:0]            WriteData_o,
  output logic                  CommandValid_o,
  output logic [7:0]            CommandData_o,
  output logic                  FrameDone_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = '0;
  localparam logic [ADDR_WIDTH-1:0] ONE_ADDR  = ADDR_WIDTH'(1);

  logic                  cs_s1_q, cs_s2_q, cs_s3_q;
  logic                  sck_s1_q, sck_s2_q, sck_s3_q;
  logic                  mosi_s1_q, mosi_s2_q;
  logic                  dc_s1_q, dc_s2_q;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [6:0]            shift_q, shift_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            wdata_q, wdata_d;
  logic                  cv_q, cv_d;
  logic [7:0]            cmd_q, cmd_d;
  logic                  frame_q, frame_d;

  logic                  sck_rise_s;
  logic                  cs_fall_s;
  logic [7:0]            byte_s;

  // Byte assembly, pointer management and next-state of the registered strobes
  always_comb begin
    sck_rise_s = sck_s2_q & ~sck_s3_q;
    cs_fall_s  = cs_s3_q & ~cs_s2_q;
    byte_s     = {shift_q, mosi_s2_q};
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cv_d       = 1'b0;
    cmd_d      = cmd_q;
    frame_d    = 1'b0;
    if (cs_fall_s) begin
      bit_cnt_d = 3'd0;
      ptr_d     = ZERO_ADDR;
    end else if (cs_s2_q) begin
      // Deselected: any partial byte is dropped and SCK is ignored
      bit_cnt_d = 3'd0;
    end else if (sck_rise_s) begin
      shift_d   = byte_s[6:0];
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        if (dc_s2_q) begin
          cv_d  = 1'b1;
          cmd_d = byte_s;
          if (byte_s == 8'h00) begin
            ptr_d = ZERO_ADDR;
          end else begin
            ptr_d = ptr_q;
          end
        end else begin
          we_d    = 1'b1;
          addr_d  = ptr_q;
          wdata_d = byte_s;
          if (ptr_q == LAST_ADDR) begin
            frame_d = 1'b1;
            ptr_d   = ZERO_ADDR;
          end else begin
            frame_d = 1'b0;
            ptr_d   = ptr_q + ONE_ADDR;
          end
        end
      end else begin
        ptr_d = ptr_q;
      end
    end else begin
      bit_cnt_d = bit_cnt_q;
    end
  end

  // Synchronizers and all state; CS stages idle high so reset never looks like a select
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cs_s1_q   <= 1'b1;
      cs_s2_q   <= 1'b1;
      cs_s3_q   <= 1'b1;
      sck_s1_q  <= 1'b0;
      sck_s2_q  <= 1'b0;
      sck_s3_q  <= 1'b0;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
      dc_s1_q   <= 1'b0;
      dc_s2_q   <= 1'b0;
      bit_cnt_q <= 3'd0;
      shift_q   <= 7'd0;
      ptr_q     <= ZERO_ADDR;
      we_q      <= 1'b0;
      addr_q    <= ZERO_ADDR;
      wdata_q   <= 8'h00;
      cv_q      <= 1'b0;
      cmd_q     <= 8'h00;
      frame_q   <= 1'b0;
    end else begin
      cs_s1_q   <= CS_i;
      cs_s2_q   <= cs_s1_q;
      cs_s3_q   <= cs_s2_q;
      sck_s1_q  <= SCK_i;
      sck_s2_q  <= sck_s1_q;
      sck_s3_q  <= sck_s2_q;
      mosi_s1_q <= MOSI_i;
      mosi_s2_q <= mosi_s1_q;
      dc_s1_q   <= DC_i;
      dc_s2_q   <= dc_s1_q;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cv_q      <= cv_d;
      cmd_q     <= cmd_d;
      frame_q   <= frame_d;
    end
  end

  assign WriteEnable_o  = we_q;
  assign WriteAddress_o = addr_q;
  assign WriteData_o    = wdata_q;
  assign CommandValid_o = cv_q;
  assign CommandData_o  = cmd_q;
  assign FrameDone_o    = frame_q;

endmodule

// File: tb/tb_spi_bitmap_writer.sv
// Randomized bench for spi_bitmap_writer: an SPI master drives bytes while a
// byte-level model predicts every RAM write and command strobe.
module tb_spi_bitmap_writer;
  localparam int DEPTH = 1536;
  localparam int AW    = 11;

  logic          Clock = 1'b0;
  logic          Reset, CS_i, SCK_i, MOSI_i, DC_i;
  logic          WriteEnable_o, CommandValid_o, FrameDone_o;
  logic [AW-1:0] WriteAddress_o;
  logic [7:0]    WriteData_o, CommandData_o;

  spi_bitmap_writer dut (
    .Clock(Clock), .Reset(Reset), .CS_i(CS_i), .SCK_i(SCK_i), .MOSI_i(MOSI_i), .DC_i(DC_i),
    .WriteEnable_o(WriteEnable_o), .WriteAddress_o(WriteAddress_o), .WriteData_o(WriteData_o),
    .CommandValid_o(CommandValid_o), .CommandData_o(CommandData_o), .FrameDone_o(FrameDone_o)
  );

  always #20 Clock = ~Clock;

  int total = 0;
  int bad   = 0;

  // reference model: byte-level view of the write pointer and expected events
  int            model_ptr = 0;
  logic [AW-1:0] exp_addr[$];
  logic [7:0]    exp_data[$];
  bit            exp_frame[$];
  logic [7:0]    exp_cmd[$];
  logic [AW-1:0] last_addr = '0;
  logic [7:0]    last_data = 8'h00;
  logic [7:0]    last_cmd  = 8'h00;
  int            frame_cnt = 0;
  logic [AW-1:0] frame_addr = '0;
  logic [AW-1:0] ea;
  logic [7:0]    ed;
  bit            ef;

  // monitor: every cycle matches DUT strobes against the model's queues
  always @(negedge Clock) begin
    if (!Reset) begin
      last_addr = '0;
      last_data = 8'h00;
      last_cmd  = 8'h00;
    end else begin
      total++;
      if (WriteEnable_o === 1'b1) begin
        if (exp_addr.size() == 0) begin
          bad++;
          $display("FAIL write_unexpected: got addr=%0d data=%h, required no write", WriteAddress_o, WriteData_o);
        end else begin
          ea = exp_addr.pop_front();
          ed = exp_data.pop_front();
          ef = exp_frame.pop_front();
          last_addr = ea;
          last_data = ed;
          if (WriteAddress_o !== ea || WriteData_o !== ed || FrameDone_o !== ef)
            begin
              bad++;
              $display("FAIL write: got addr=%0d data=%h frame=%b, required addr=%0d data=%h frame=%b",
                       WriteAddress_o, WriteData_o, FrameDone_o, ea, ed, ef);
            end
        end
      end else if (WriteEnable_o !== 1'b0 || FrameDone_o !== 1'b0 ||
                   WriteAddress_o !== last_addr || WriteData_o !== last_data) begin
        bad++;
        $display("FAIL write_hold: got we=%b frame=%b addr=%0d data=%h, required we=0 frame=0 addr=%0d data=%h",
                 WriteEnable_o, FrameDone_o, WriteAddress_o, WriteData_o, last_addr, last_data);
      end
      if (FrameDone_o === 1'b1) begin
        frame_cnt++;
        frame_addr = WriteAddress_o;
      end
      total++;
      if (CommandValid_o === 1'b1) begin
        if (exp_cmd.size() == 0) begin
          bad++;
          $display("FAIL cmd_unexpected: got cmd=%h, required no command", CommandData_o);
        end else begin
          ed = exp_cmd.pop_front();
          last_cmd = ed;
          if (CommandData_o !== ed) begin
            bad++;
            $display("FAIL cmd: got %h, required %h", CommandData_o, ed);
          end
        end
      end else if (CommandValid_o !== 1'b0 || CommandData_o !== last_cmd) begin
        bad++;
        $display("FAIL cmd_hold: got valid=%b cmd=%h, required valid=0 cmd=%h", CommandValid_o, CommandData_o, last_cmd);
      end
    end
  end

  // stimulus stays 10 ns off the clock grid so SPI edges never coincide with Clock edges
  task automatic idle(input int n);
    repeat (n) @(negedge Clock);
    #10;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit dc);
    if (!dc) begin
      exp_addr.push_back(AW'(model_ptr));
      exp_data.push_back(b);
      exp_frame.push_back(model_ptr == DEPTH - 1);
      model_ptr = (model_ptr + 1) % DEPTH;
    end else begin
      exp_cmd.push_back(b);
      if (b == 8'h00) model_ptr = 0;
    end
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n, input bit dc);
    for (int i = 7; i > 7 - n; i--) begin
      MOSI_i = b[i];
      DC_i   = dc;
      #100 SCK_i = 1'b1;
      #100 SCK_i = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] b, input bit dc);
    model_byte(b, dc);
    spi_bits(b, 8, dc);
  endtask

  task automatic cs_low();
    CS_i = 1'b0;
    model_ptr = 0;
    #100;
  endtask

  task automatic cs_high();
    #100 CS_i = 1'b1;
    #200;
  endtask

  task automatic test_reset();
    Reset = 1'b0; CS_i = 1'b1; SCK_i = 1'b0; MOSI_i = 1'b0; DC_i = 1'b0;
    #30;
    total++;
    if ({WriteEnable_o, WriteAddress_o, WriteData_o, CommandValid_o, CommandData_o, FrameDone_o} !== 30'd0) begin
      bad++;
      $display("FAIL reset_outputs: got we=%b addr=%0d data=%h cv=%b cmd=%h frame=%b, required all 0",
               WriteEnable_o, WriteAddress_o, WriteData_o, CommandValid_o, CommandData_o, FrameDone_o);
    end
    idle(3);
    Reset = 1'b1;
    idle(1000);
    total++;
    if ({WriteEnable_o, WriteAddress_o, WriteData_o, CommandValid_o, CommandData_o, FrameDone_o} !== 30'd0 ||
        frame_cnt != 0) begin
      bad++;
      $display("FAIL idle_outputs: got we=%b addr=%0d data=%h cmd=%h frames=%0d, required all 0",
               WriteEnable_o, WriteAddress_o, WriteData_o, CommandData_o, frame_cnt);
    end
  endtask

  task automatic test_basic();
    cs_low();
    spi_byte(8'h01, 1'b0);
    spi_byte(8'h03, 1'b0);
    spi_byte(8'h07, 1'b0);
    spi_byte(8'h0F, 1'b0);
    cs_high();
    idle(10);
    total++;
    if (exp_addr.size() != 0 || WriteAddress_o !== 11'd3 || WriteData_o !== 8'h0F) begin
      bad++;
      $display("FAIL basic: got pending=%0d addr=%0d data=%h, required pending=0 addr=3 data=0f",
               exp_addr.size(), WriteAddress_o, WriteData_o);
    end
  endtask

  task automatic test_frame();
    int f0;
    f0 = frame_cnt;
    cs_low();
    for (int i = 0; i < DEPTH; i++) spi_byte(((i % 2) == 0) ? 8'hFF : 8'h00, 1'b0);
    idle(10);
    total++;
    if (frame_cnt - f0 != 1 || frame_addr !== 11'd1535 || exp_addr.size() != 0) begin
      bad++;
      $display("FAIL frame_done: got pulses=%0d addr=%0d pending=%0d, required pulses=1 addr=1535 pending=0",
               frame_cnt - f0, frame_addr, exp_addr.size());
    end
    spi_byte(8'hAA, 1'b0);
    cs_high();
    idle(10);
    total++;
    if (exp_addr.size() != 0 || WriteAddress_o !== 11'd0 || WriteData_o !== 8'hAA) begin
      bad++;
      $display("FAIL frame_wrap: got pending=%0d addr=%0d data=%h, required pending=0 addr=0 data=aa",
               exp_addr.size(), WriteAddress_o, WriteData_o);
    end
  endtask

  task automatic test_abort();
    cs_low();
    spi_bits(8'hF0, 5, 1'b0);
    cs_high();
    cs_low();
    spi_byte(8'h3C, 1'b0);
    cs_high();
    idle(10);
    total++;
    if (exp_addr.size() != 0 || WriteAddress_o !== 11'd0 || WriteData_o !== 8'h3C) begin
      bad++;
      $display("FAIL abort: got pending=%0d addr=%0d data=%h, required pending=0 addr=0 data=3c",
               exp_addr.size(), WriteAddress_o, WriteData_o);
    end
  endtask

  task automatic test_command();
    cs_low();
    spi_byte(8'h11, 1'b0);
    spi_byte(8'h22, 1'b0);
    spi_byte(8'h00, 1'b1);
    spi_byte(8'h33, 1'b0);
    spi_byte(8'hAF, 1'b1);
    spi_byte(8'h44, 1'b0);
    cs_high();
    idle(10);
    total++;
    if (exp_addr.size() != 0 || exp_cmd.size() != 0 || CommandData_o !== 8'hAF ||
        WriteAddress_o !== 11'd1 || WriteData_o !== 8'h44) begin
      bad++;
      $display("FAIL command: got pending=%0d/%0d cmd=%h addr=%0d data=%h, required 0/0 cmd=af addr=1 data=44",
               exp_addr.size(), exp_cmd.size(), CommandData_o, WriteAddress_o, WriteData_o);
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    bit         dc;
    cs_low();
    for (int i = 0; i < 40; i++) begin
      dc = ($urandom_range(0, 3) == 0);
      b  = 8'($urandom_range(0, 255));
      if (dc && $urandom_range(0, 1) == 1) b = 8'h00;
      spi_byte(b, dc);
    end
    cs_high();
    idle(10);
    total++;
    if (exp_addr.size() != 0 || exp_cmd.size() != 0) begin
      bad++;
      $display("FAIL random: got pending writes=%0d cmds=%0d, required 0 and 0", exp_addr.size(), exp_cmd.size());
    end
  endtask

  task automatic test_reset_mid();
    cs_low();
    spi_byte(8'h5A, 1'b0);
    spi_byte(8'h77, 1'b0);
    spi_bits(8'hC3, 3, 1'b0);
    MOSI_i = 1'b0;
    #100 SCK_i = 1'b1;
    #40 Reset = 1'b0;
    #1;
    total++;
    if ({WriteEnable_o, WriteAddress_o, WriteData_o, CommandValid_o, CommandData_o, FrameDone_o} !== 30'd0) begin
      bad++;
      $display("FAIL reset_mid: got we=%b addr=%0d data=%h cv=%b cmd=%h frame=%b, required all 0",
               WriteEnable_o, WriteAddress_o, WriteData_o, CommandValid_o, CommandData_o, FrameDone_o);
    end
    #59 SCK_i = 1'b0;
    CS_i = 1'b1;
    model_ptr = 0;
    idle(5);
    Reset = 1'b1;
    idle(5);
    cs_low();
    spi_byte(8'h42, 1'b0);
    cs_high();
    idle(10);
    total++;
    if (exp_addr.size() != 0 || WriteAddress_o !== 11'd0 || WriteData_o !== 8'h42) begin
      bad++;
      $display("FAIL reset_restart: got pending=%0d addr=%0d data=%h, required pending=0 addr=0 data=42",
               exp_addr.size(), WriteAddress_o, WriteData_o);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_frame();
    test_abort();
    test_command();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
